adder_pipe: RTL and testbench

Multi-lane, pipelined add/subtract unit with valid/ready handshakes on input and output. It is the parametrised successor of the single-lane registered adder, generalised in width, lane count and pipeline depth. It adds a subtract mode, per-lane carry/borrow, backpressure support and a completed-transaction counter. It sits between a data producer and consumer in datapath designs and is the standard arithmetic stage for bench and RTL reuse.

---
 rtl/adder_pipe.sv | 126 ++++++++++++
 tb/tb_adder_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: multi-lane pipelined add/subtract stage with valid/ready
// handshakes on both sides and a completed-transaction counter.
// Optional feature macro: ADDER_PIPE_SAT_EN (saturating results when defined).
module adder_pipe #(
    parameter int DataWidth = 8,
    parameter int NumLanes  = 4,
    parameter int NumStages = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic                          sub_i,
    input  logic [NumLanes*DataWidth-1:0] a_data_i,
    input  logic [NumLanes*DataWidth-1:0] b_data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NumLanes*DataWidth-1:0] c_data_o,
    output logic [NumLanes-1:0]           carry_o,
    output logic [31:0]                   count_o
);

    localparam int BusWidth = NumLanes * DataWidth;

    logic [BusWidth-1:0]  result_d;
    logic [NumLanes-1:0]  carry_d;
    logic [DataWidth-1:0] laneA;
    logic [DataWidth-1:0] laneB;
    logic [DataWidth:0]   laneWide;

    logic [NumStages-1:0] valid_q;
    logic [BusWidth-1:0]  data_q  [NumStages];
    logic [NumLanes-1:0]  carry_q [NumStages];
    logic [31:0]          count_q;

    logic [NumStages-1:0] stageEn;
    logic                 allFull;
    logic [NumStages-1:0] inValid;
    logic [BusWidth-1:0]  inData  [NumStages];
    logic [NumLanes-1:0]  inCarry [NumStages];

    // Per-lane arithmetic at DataWidth+1 bits; the top bit is carry (add) or borrow (sub).
    always_comb begin
        result_d = '0;
        carry_d  = '0;
        laneA    = '0;
        laneB    = '0;
        laneWide = '0;
        for (int k = 0; k < NumLanes; k++) begin
            laneA = a_data_i[k*DataWidth +: DataWidth];
            laneB = b_data_i[k*DataWidth +: DataWidth];
            if (sub_i) begin
                laneWide = {1'b0, laneA} - {1'b0, laneB};
            end else begin
                laneWide = {1'b0, laneA} + {1'b0, laneB};
            end
            carry_d[k] = laneWide[DataWidth];
            result_d[k*DataWidth +: DataWidth] = laneWide[DataWidth-1:0];
`ifdef ADDER_PIPE_SAT_EN
            if (laneWide[DataWidth]) begin
                result_d[k*DataWidth +: DataWidth] = sub_i ? {DataWidth{1'b0}} : {DataWidth{1'b1}};
            end
`endif
        end
    end

    // A stage may load when it is empty or every stage below it is able to move; this collapses bubbles.
    always_comb begin
        allFull = 1'b1;
        stageEn = '0;
        for (int s = NumStages - 1; s >= 0; s--) begin
            allFull    = allFull & valid_q[s];
            stageEn[s] = ready_i | ~allFull;
        end
    end

    // Stage inputs: stage 0 takes the fresh arithmetic result, later stages take their predecessor.
    always_comb begin
        inValid    = '0;
        inValid[0] = valid_i;
        inData[0]  = result_d;
        inCarry[0] = carry_d;
        for (int s = 1; s < NumStages; s++) begin
            inValid[s] = valid_q[s-1];
            inData[s]  = data_q[s-1];
            inCarry[s] = carry_q[s-1];
        end
    end

    // Pipeline registers; data only changes when a valid item is captured so stalled outputs hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 0; s < NumStages; s++) begin
                data_q[s]  <= '0;
                carry_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NumStages; s++) begin
                if (stageEn[s]) begin
                    valid_q[s] <= inValid[s];
                    if (inValid[s]) begin
                        data_q[s]  <= inData[s];
                        carry_q[s] <= inCarry[s];
                    end
                end
            end
        end
    end

    // Completed-transaction counter, wraps naturally at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (valid_o && ready_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign ready_o  = stageEn[0];
    assign valid_o  = valid_q[NumStages-1];
    assign c_data_o = data_q[NumStages-1];
    assign carry_o  = carry_q[NumStages-1];
    assign count_o  = count_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and random checks of adder_pipe (default parameters)
// against a queue-based scoreboard. Honours ADDER_PIPE_SAT_EN for expected values.
module tb_adder_pipe;

    localparam int DW = 8;
    localparam int NL = 4;
    localparam int BW = DW * NL;

    logic          clk_i;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic          sub_i;
    logic [BW-1:0] a_data_i;
    logic [BW-1:0] b_data_i;
    logic          valid_o;
    logic          ready_i;
    logic [BW-1:0] c_data_o;
    logic [NL-1:0] carry_o;
    logic [31:0]   count_o;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [NL-1:0] carry;
    } exp_t;

    exp_t        sbQ[$];
    int          checks   = 0;
    int          failures = 0;
    int          nAccepted = 0;
    logic [31:0] expCount = 0;

    adder_pipe dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sub_i    (sub_i),
        .a_data_i (a_data_i),
        .b_data_i (b_data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .c_data_o (c_data_o),
        .carry_o  (carry_o),
        .count_o  (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model written lane by lane in integer arithmetic.
    function automatic exp_t model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic s);
        exp_t e;
        int   x;
        int   y;
        int   r;
        e = '0;
        for (int k = 0; k < NL; k++) begin
            x = int'(a[k*DW +: DW]);
            y = int'(b[k*DW +: DW]);
            if (!s) begin
                e.carry[k] = (x + y) >= (1 << DW);
                r = (x + y) % (1 << DW);
`ifdef ADDER_PIPE_SAT_EN
                if (e.carry[k]) r = (1 << DW) - 1;
`endif
            end else begin
                e.carry[k] = (x < y);
                r = (x + (1 << DW) - y) % (1 << DW);
`ifdef ADDER_PIPE_SAT_EN
                if (e.carry[k]) r = 0;
`endif
            end
            e.data[k*DW +: DW] = r[DW-1:0];
        end
        return e;
    endfunction

    // Drive one cycle of inputs, score the handshakes seen this cycle, then advance past the edge.
    task automatic applyStimulus(input logic v, input logic s, input logic r,
                                 input logic [BW-1:0] a, input logic [BW-1:0] b);
        exp_t e;
        logic acc;
        logic emit;
        valid_i  = v;
        sub_i    = s;
        ready_i  = r;
        a_data_i = a;
        b_data_i = b;
        #1;
        checkOutput("count", count_o, expCount);
        acc  = v && ready_o;
        emit = valid_o && r;
        if (emit) begin
            checkOutput("sb_nonempty", sbQ.size() != 0, 1);
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                checkOutput("sb_data", c_data_o, e.data);
                checkOutput("sb_carry", carry_o, e.carry);
            end
            expCount++;
        end
        if (acc) begin
            sbQ.push_back(model(a, b, s));
            nAccepted++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        #2;
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_count", count_o, 0);
        rst_i = 1'b0;
        sbQ.delete();
        expCount = 0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int cyc;
        int startAcc;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        sub_i    = 1'b0;
        ready_i  = 1'b1;
        a_data_i = '0;
        b_data_i = '0;
        #2;
        $display("[TB] reset state");
        checkOutput("init_valid", valid_o, 0);
        checkOutput("init_data", c_data_o, 0);
        checkOutput("init_carry", carry_o, 0);
        checkOutput("init_count", count_o, 0);
        checkOutput("init_ready", ready_o, 1);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        $display("[TB] latency and basic add");
        applyStimulus(1, 0, 1, 32'h0000_0010, 32'h0000_0020);
        checkOutput("t1_valid_c1", valid_o, 0);
        applyStimulus(0, 0, 1, '0, '0);
        checkOutput("t1_valid_c2", valid_o, 1);
        checkOutput("t1_lane0", c_data_o[7:0], 8'h30);
        checkOutput("t1_carry0", carry_o[0], 0);
        applyStimulus(0, 0, 1, '0, '0);
        checkOutput("t1_valid_c3", valid_o, 0);

        $display("[TB] add overflow");
        applyStimulus(1, 0, 1, 32'h0000_FF00, 32'h0000_0100);
        applyStimulus(0, 0, 1, '0, '0);
`ifdef ADDER_PIPE_SAT_EN
        checkOutput("t2_lane1", c_data_o[15:8], 8'hFF);
`else
        checkOutput("t2_lane1", c_data_o[15:8], 8'h00);
`endif
        checkOutput("t2_carry1", carry_o[1], 1);
        applyStimulus(0, 0, 1, '0, '0);

        $display("[TB] subtract borrow and no-borrow");
        applyStimulus(1, 1, 1, 32'h0005_0000, 32'h0007_0000);
        applyStimulus(1, 1, 1, 32'h0007_0000, 32'h0005_0000);
`ifdef ADDER_PIPE_SAT_EN
        checkOutput("t3_lane2_borrow", c_data_o[23:16], 8'h00);
`else
        checkOutput("t3_lane2_borrow", c_data_o[23:16], 8'hFE);
`endif
        checkOutput("t3_carry2_borrow", carry_o[2], 1);
        applyStimulus(0, 0, 1, '0, '0);
        checkOutput("t3_lane2", c_data_o[23:16], 8'h02);
        checkOutput("t3_carry2", carry_o[2], 0);
        applyStimulus(0, 0, 1, '0, '0);

        $display("[TB] backpressure");
        doReset();
        applyStimulus(1, 0, 0, 32'h0101_0101, 32'h0202_0202);
        applyStimulus(1, 1, 0, 32'h0909_0909, 32'h0404_0404);
        checkOutput("t4_ready_full", ready_o, 0);
        applyStimulus(1, 0, 0, 32'h8080_8080, 32'h9090_9090);
        checkOutput("t4_acc_two", nAccepted >= 2 && sbQ.size() == 2, 1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("t4_stall_valid", valid_o, 1);
            checkOutput("t4_stall_data", c_data_o, sbQ[0].data);
            checkOutput("t4_stall_carry", carry_o, sbQ[0].carry);
            applyStimulus(1, 0, 0, 32'h8080_8080, 32'h9090_9090);
        end
        applyStimulus(1, 0, 1, 32'h8080_8080, 32'h9090_9090);
        applyStimulus(0, 0, 1, '0, '0);
        applyStimulus(0, 0, 1, '0, '0);
        checkOutput("t4_count", count_o, 3);
        checkOutput("t4_drained", sbQ.size(), 0);

        $display("[TB] asynchronous reset with work in flight");
        applyStimulus(1, 0, 0, 32'h1111_1111, 32'h2222_2222);
        applyStimulus(1, 0, 0, 32'h3333_3333, 32'h4444_4444);
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        checkOutput("t5_pre_valid", valid_o, 1);
        rst_i = 1'b1;
        #1;
        checkOutput("t5_valid", valid_o, 0);
        checkOutput("t5_count", count_o, 0);
        checkOutput("t5_data", c_data_o, 0);
        rst_i = 1'b0;
        sbQ.delete();
        expCount = 0;
        @(posedge clk_i);
        #1;
        checkOutput("t5_ready", ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, '0, '0);
            checkOutput("t5_no_stale", valid_o, 0);
        end

        $display("[TB] random traffic");
        startAcc = nAccepted;
        cyc = 0;
        while ((nAccepted - startAcc) < 1000 && cyc < 20000) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0), $urandom, $urandom);
            cyc++;
        end
        checkOutput("rand_accepted", (nAccepted - startAcc) >= 1000, 1);
        cyc = 0;
        while (sbQ.size() != 0 && cyc < 200) begin
            applyStimulus(0, 0, 1, '0, '0);
            cyc++;
        end
        checkOutput("rand_drained", sbQ.size(), 0);
        checkOutput("rand_valid_idle", valid_o, 0);
        checkOutput("rand_count", count_o, expCount);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
